// File: rtl/inv_resp_checker_pkg.sv
// -----------------------------------------------------------------------------
// inv_resp_checker_pkg
//   Shared definitions for the inverting-cell response checker and for the
//   gate checkers that will reuse its settle timer.
//
//   Contents:
//     state_t       checker FSM state, 3-bit encoding (also driven on the
//                   state_dbg port of the checker)
//     TIMER_W       width of the settle timer; covers settle times 1..255
//     SETTLE_MIN/MAX legal settle-time range
//     settle_load() timer reload value for a given settle time
// -----------------------------------------------------------------------------
package inv_resp_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_STIM = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_CHECK     = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam int TIMER_W    = 8;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 255;

    // The timer is loaded on the stim edge and the sample is taken on the edge
    // where it reads zero, so loading N-1 puts the sample N edges after stim.
    function automatic logic [TIMER_W-1:0] settle_load(input int settle_cyc);
        return TIMER_W'(settle_cyc - 1);
    endfunction

endpackage

// File: rtl/inv_resp_checker_settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
//   Loadable down-counter. Loading takes priority; otherwise the count
//   decrements once per cycle and parks at zero.
//
//   Ports:
//     clk    in   1   rising-edge clock
//     rst_n  in   1   asynchronous active-low reset (count -> 0)
//     load   in   1   load val this cycle
//     val    in   W   reload value
//     zero   out  1   count is zero (decoded from the count register)
// -----------------------------------------------------------------------------
module settle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/inv_resp_checker.sv
// -----------------------------------------------------------------------------
// inv_resp_checker
//   Response-side checker for single-bit inverting cells. For each stimulus
//   pulse it waits SETTLE_CYC cycles, samples dut_y and checks dut_y == ~stim_a.
//   A run of NUM_CHECKS checks is started by a start pulse; the result is
//   reported with a one-cycle done pulse and a held pass flag.
//
//   Handshake: start and stim_valid are single-cycle qualifiers sampled on the
//   rising edge; there is no back-pressure. start is acted on only when no run
//   is in progress (busy low). A stim_valid is accepted while waiting for
//   stimulus; one that arrives during settling restarts the settle window and
//   sets overrun; one that arrives in the check cycle or outside a run is
//   dropped (the check-cycle case also sets overrun).
//
//   Ports:
//     clk              in   1      rising-edge clock
//     rst_n            in   1      asynchronous active-low reset
//     start            in   1      begin a run (ignored while busy)
//     stim_valid       in   1      stim_a was applied to the DUT this cycle
//     stim_a           in   1      stimulus bit driven to the DUT
//     dut_y            in   1      DUT output under check
//     busy             out  1      run in progress
//     done             out  1      one-cycle end-of-run pulse
//     pass             out  1      no mismatches and no overrun; held
//     overrun          out  1      sticky: stimulus arrived while settling/checking
//     chk_cnt          out  CNT_W  checks completed in this run
//     err_cnt          out  CNT_W  mismatches, saturating
//     first_err_valid  out  1      first failure captured
//     first_err_idx    out  CNT_W  chk_cnt value at the first mismatch
//     state_dbg        out  3      current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module inv_resp_checker
    import inv_resp_checker_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int NUM_CHECKS = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stim_valid,
    input  logic             stim_a,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             overrun,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [2:0]       state_dbg
);

    localparam logic [CNT_W-1:0]   CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   LAST_CNT    = CNT_W'(NUM_CHECKS);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = settle_load(SETTLE_CYC);

    // Reject parameter sets the counters or the timer cannot represent.
    if ((SETTLE_CYC < SETTLE_MIN) || (SETTLE_CYC > SETTLE_MAX)) begin : g_bad_settle
        $error("inv_resp_checker: SETTLE_CYC out of range 1..255");
    end
    if ((NUM_CHECKS < 1) || (NUM_CHECKS > (2 ** CNT_W) - 1)) begin : g_bad_checks
        $error("inv_resp_checker: NUM_CHECKS out of range 1..2**CNT_W-1");
    end

    state_t           state;
    logic             exp_y;        // expected DUT output for the pending check
    logic             sample_mis;   // mismatch captured when settling ends
    logic             timer_load;
    logic             timer_zero;
    logic [CNT_W-1:0] err_next;
    logic [CNT_W-1:0] chk_next;
    logic             ovr_next;

    // The timer restarts on every accepted stimulus, including the one that
    // causes an overrun, so the sample always follows the latest stimulus.
    assign timer_load = stim_valid && ((state == ST_WAIT_STIM) || (state == ST_SETTLE));

    settle_timer #(
        .W (TIMER_W)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .val   (SETTLE_LOAD),
        .zero  (timer_zero)
    );

    always_comb begin
        err_next = err_cnt;
        if (sample_mis && (err_cnt != CNT_MAX)) begin
            err_next = err_cnt + 1'b1;
        end
        chk_next = chk_cnt + 1'b1;
        // A stimulus in the check cycle is dropped but still flags overrun,
        // and must be reflected in the pass verdict of a finishing run.
        ovr_next = overrun | stim_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            overrun         <= 1'b0;
            chk_cnt         <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            exp_y           <= 1'b0;
            sample_mis      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    // DONE is the cycle done is high; a start here is as good
                    // as one in IDLE because busy is already low.
                    if (start) begin
                        busy            <= 1'b1;
                        pass            <= 1'b0;
                        overrun         <= 1'b0;
                        chk_cnt         <= '0;
                        err_cnt         <= '0;
                        first_err_valid <= 1'b0;
                        first_err_idx   <= '0;
                        sample_mis      <= 1'b0;
                        state           <= ST_WAIT_STIM;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_WAIT_STIM: begin
                    if (stim_valid) begin
                        exp_y <= ~stim_a;
                        state <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (stim_valid) begin
                        overrun <= 1'b1;
                        exp_y   <= ~stim_a;
                    end else if (timer_zero) begin
                        // dut_y is sampled on this edge so the sample lands
                        // exactly SETTLE_CYC edges after the stimulus; CHECK
                        // then books the result. X/Z on dut_y counts as a
                        // mismatch in simulation.
                        sample_mis <= (dut_y !== exp_y);
                        state      <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    overrun <= ovr_next;
                    err_cnt <= err_next;
                    if (sample_mis && !first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_idx   <= chk_cnt;
                    end
                    chk_cnt <= chk_next;
                    if (chk_next == LAST_CNT) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (err_next == '0) && !ovr_next;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_WAIT_STIM;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_inv_resp_checker.sv
module tb_inv_resp_checker;

    localparam int S_MAIN  = 2;
    localparam int N_MAIN  = 4;
    localparam int W       = 8;
    localparam int S_LONG  = 1;
    localparam int N_LONG  = 255;
    localparam int CNT_MAX = (1 << W) - 1;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (4 checks, settle 2) ----------------
    logic         start, stim_valid, stim_a, dut_y;
    logic         busy, done, pass, overrun, first_err_valid;
    logic [W-1:0] chk_cnt, err_cnt, first_err_idx;
    logic [2:0]   state_dbg;

    inv_resp_checker #(
        .SETTLE_CYC (S_MAIN),
        .NUM_CHECKS (N_MAIN),
        .CNT_W      (W)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .stim_valid      (stim_valid),
        .stim_a          (stim_a),
        .dut_y           (dut_y),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .overrun         (overrun),
        .chk_cnt         (chk_cnt),
        .err_cnt         (err_cnt),
        .first_err_valid (first_err_valid),
        .first_err_idx   (first_err_idx),
        .state_dbg       (state_dbg)
    );

    // ---------------- long DUT (255 checks, settle 1) ----------------
    logic         l_start, l_stim_valid, l_stim_a, l_dut_y;
    logic         l_busy, l_done, l_pass, l_overrun, l_first_err_valid;
    logic [W-1:0] l_chk_cnt, l_err_cnt, l_first_err_idx;
    logic [2:0]   l_state_dbg;

    inv_resp_checker #(
        .SETTLE_CYC (S_LONG),
        .NUM_CHECKS (N_LONG),
        .CNT_W      (W)
    ) u_dut_long (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (l_start),
        .stim_valid      (l_stim_valid),
        .stim_a          (l_stim_a),
        .dut_y           (l_dut_y),
        .busy            (l_busy),
        .done            (l_done),
        .pass            (l_pass),
        .overrun         (l_overrun),
        .chk_cnt         (l_chk_cnt),
        .err_cnt         (l_err_cnt),
        .first_err_valid (l_first_err_valid),
        .first_err_idx   (l_first_err_idx),
        .state_dbg       (l_state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];   // per-check expected mismatch flag of the current run

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behaviour of the cell under test: 0 good inverter, 1 stuck-at-0,
    // 2 stuck-at-1, 3 inverter with a random per-check flip.
    function automatic logic model_y(input int mode, input logic a, input logic flip);
        case (mode)
            0:       return ~a;
            1:       return 1'b0;
            2:       return 1'b1;
            default: return ~a ^ flip;
        endcase
    endfunction

    // Reduce the expected queue to the run verdict and compare with the DUT.
    task automatic score_run(input string tag, input logic ovr, input int n_exp,
                             input logic d, input logic b, input logic p, input logic o,
                             input logic [W-1:0] cc, input logic [W-1:0] ec,
                             input logic fv, input logic [W-1:0] fi);
        int errs, first_idx, idx;
        errs = 0; first_idx = 0; idx = 0;
        while (exp_q.size() > 0) begin
            if (exp_q.pop_front() != '0) begin
                if (errs == 0) first_idx = idx;
                errs++;
            end
            idx++;
        end
        check({tag, "_done"},      32'(d),  32'd1);
        check({tag, "_busy"},      32'(b),  32'd0);
        check({tag, "_chk_cnt"},   32'(cc), 32'(n_exp));
        check({tag, "_err_cnt"},   32'(ec), 32'((errs > CNT_MAX) ? CNT_MAX : errs));
        check({tag, "_overrun"},   32'(o),  32'(ovr));
        check({tag, "_pass"},      32'(p),  32'((errs == 0) && !ovr));
        check({tag, "_first_vld"}, 32'(fv), 32'(errs > 0));
        check({tag, "_first_idx"}, 32'(fi), 32'(first_idx));
    endtask

    // ---------------- driver: one run on the main DUT ----------------
    task automatic run_main(input string tag, input int mode, input bit directed,
                            input bit extras, input int dbl_slot);
        logic a, a_last, flip, ovr, late, dbl, y;
        logic p_hold;
        ovr = 1'b0;
        exp_q.delete();
        @(negedge clk);
        start      = 1'b1;
        // a stim_valid alongside start must not be counted
        stim_valid = extras ? 1'($urandom_range(0, 1)) : 1'b0;
        stim_a     = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0; stim_valid = 1'b0;
        check({tag, "_busy_start"},  32'(busy),    32'd1);
        check({tag, "_chk_clear"},   32'(chk_cnt), 32'd0);
        check({tag, "_pass_clear"},  32'(pass),    32'd0);
        for (int k = 0; k < N_MAIN; k++) begin
            if (!directed) repeat ($urandom_range(0, 2)) @(negedge clk);
            a    = directed ? 1'(k % 2) : 1'($urandom_range(0, 1));
            flip = 1'($urandom_range(0, 1));
            y    = model_y(mode, a, flip);
            stim_valid = 1'b1; stim_a = a; dut_y = y;
            start      = extras && ($urandom_range(0, 2) == 0);  // ignored while busy
            a_last     = a;
            @(negedge clk);
            stim_valid = 1'b0; start = 1'b0;
            dbl = (k == dbl_slot) || (extras && ($urandom_range(0, 3) == 0));
            if (dbl) begin
                a    = 1'($urandom_range(0, 1));
                flip = 1'($urandom_range(0, 1));
                y    = model_y(mode, a, flip);
                stim_valid = 1'b1; stim_a = a; dut_y = y;
                a_last = a;
                ovr    = 1'b1;
                @(negedge clk);
                stim_valid = 1'b0;
            end
            exp_q.push_back(W'(y != ~a_last));
            late = extras && ($urandom_range(0, 5) == 0);
            for (int c = 0; c <= S_MAIN; c++) begin
                // c == S_MAIN drives the check-cycle edge: dropped, sets overrun
                if (late && (c == S_MAIN)) begin
                    stim_valid = 1'b1;
                    ovr        = 1'b1;
                end
                @(negedge clk);
                stim_valid = 1'b0;
            end
            if (k < N_MAIN - 1) begin
                check({tag, "_no_early_done"}, 32'(done),    32'd0);
                check({tag, "_chk_progress"},  32'(chk_cnt), 32'(k + 1));
            end
        end
        score_run(tag, ovr, N_MAIN, done, busy, pass, overrun,
                  chk_cnt, err_cnt, first_err_valid, first_err_idx);
        p_hold = pass;
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_pass_held"},  32'(pass), 32'(p_hold));
    endtask

    // ---------------- reset during the settle of check 2 ----------------
    task automatic reset_mid_run();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stim_valid = 1'b1; stim_a = 1'b0; dut_y = 1'b1;
        @(negedge clk);
        stim_valid = 1'b0;
        repeat (S_MAIN + 1) @(negedge clk);
        check("rst_pre_chk_cnt", 32'(chk_cnt), 32'd1);
        stim_valid = 1'b1; stim_a = 1'b1; dut_y = 1'b1;   // bad output, would err
        @(negedge clk);
        stim_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_busy",    32'(busy),            32'd0);
        check("rst_async_chk",     32'(chk_cnt),         32'd0);
        check("rst_async_done",    32'(done),            32'd0);
        check("rst_async_err",     32'(err_cnt),         32'd0);
        check("rst_async_fvld",    32'(first_err_valid), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("rst_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        repeat (S_MAIN + 2) begin
            @(negedge clk);
            check("rst_stays_idle", 32'(busy | done), 32'd0);
        end
    endtask

    // ---------------- long run: stuck-at-1 cell, alternating stim ----------------
    task automatic run_long();
        logic a;
        exp_q.delete();
        @(negedge clk);
        l_start = 1'b1;
        @(negedge clk);
        l_start = 1'b0;
        for (int k = 0; k < N_LONG; k++) begin
            a = 1'((k % 2) == 0);           // 1,0,1,0,...
            l_stim_valid = 1'b1; l_stim_a = a;
            exp_q.push_back(W'(l_dut_y != ~a));
            @(negedge clk);
            l_stim_valid = 1'b0;
            repeat (S_LONG + 1) @(negedge clk);
        end
        score_run("long", 1'b0, N_LONG, l_done, l_busy, l_pass, l_overrun,
                  l_chk_cnt, l_err_cnt, l_first_err_valid, l_first_err_idx);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        start = 1'b0; stim_valid = 1'b0; stim_a = 1'b0; dut_y = 1'b0;
        l_start = 1'b0; l_stim_valid = 1'b0; l_stim_a = 1'b0; l_dut_y = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy",     32'(busy),            32'd0);
        check("reset_done",     32'(done),            32'd0);
        check("reset_pass",     32'(pass),            32'd0);
        check("reset_overrun",  32'(overrun),         32'd0);
        check("reset_chk_cnt",  32'(chk_cnt),         32'd0);
        check("reset_err_cnt",  32'(err_cnt),         32'd0);
        check("reset_fvld",     32'(first_err_valid), 32'd0);
        check("reset_fidx",     32'(first_err_idx),   32'd0);
        check("reset_l_busy",   32'(l_busy),          32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_main("good",    0, 1'b1, 1'b0, -1);
        run_main("stuck0",  1, 1'b1, 1'b0, -1);
        run_main("stuck1",  2, 1'b1, 1'b0, -1);
        run_main("overrun", 0, 1'b1, 1'b0,  1);
        reset_mid_run();
        run_main("after_rst", 0, 1'b1, 1'b0, -1);
        run_main("extras",    0, 1'b0, 1'b1, -1);
        for (int r = 0; r < 20; r++) begin
            run_main("rand", int'($urandom_range(0, 3)), 1'b0, 1'b1, -1);
        end
        run_long();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
